// File: rtl/led_pulse_stretch_pkg.sv
// rtl/led_pulse_stretch_pkg.sv - shared types for the LED pulse stretcher
package led_pulse_stretch_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOn   = 2'd1,
        StGap  = 2'd2
    } led_stretch_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sat_updown_counter.sv
// rtl/sat_updown_counter.sv - saturating up/down counter with registered drop pulse
module sat_updown_counter #(
    parameter int Max = 7,
    localparam int W = $clog2(Max + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         drop
);

    localparam logic [W-1:0] MaxC = W'(Max);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            drop  <= 1'b0;
        end else begin
            drop <= 1'b0;
            // Simultaneous inc and dec cancel, so a full counter never drops then.
            if (inc && !dec) begin
                if (count == MaxC) begin
                    drop <= 1'b1;
                end else begin
                    count <= count + W'(1);
                end
            end else if (dec && !inc && count != '0) begin
                count <= count - W'(1);
            end
        end
    end

endmodule

// File: rtl/led_pulse_stretch.sv
// rtl/led_pulse_stretch.sv - event strobe to visible LED pulse; LED_PULSE_STRETCH_QUEUE_EN enables event queueing
module led_pulse_stretch
    import led_pulse_stretch_pkg::*;
#(
    parameter int OnCount    = 500,
    parameter int GapCount   = 500,
    parameter int MaxPending = 7,
    localparam int PendW     = $clog2(MaxPending + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             evt_i,
    output logic             out_o,
    output logic             busy_o,
    output logic [PendW-1:0] pending_o,
    output logic             overflow_o
);

    localparam int CntW = $clog2(max_int(OnCount, GapCount) + 1);
    localparam logic [CntW-1:0] OnLast  = CntW'(OnCount - 1);
    localparam logic [CntW-1:0] GapLast = CntW'(GapCount - 1);

    led_stretch_state_e state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               terminal;
    logic               has_pending;
    logic               out_q, busy_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= (state_d == StOn);
            busy_q  <= (state_d != StIdle);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CntW'(1);
        terminal = 1'b0;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (evt_i) begin
                    state_d = StOn;
                end
            end
            StOn: begin
                if (cnt_q == OnLast) begin
                    state_d = StGap;
                    cnt_d   = '0;
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    terminal = 1'b1;
                    cnt_d    = '0;
                    state_d  = (has_pending || evt_i) ? StOn : StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign out_o  = out_q;
    assign busy_o = busy_q;

`ifdef LED_PULSE_STRETCH_QUEUE_EN
    logic inc, dec;

    assign has_pending = (pending_o != '0);
    // An event on the terminal gap cycle with an empty queue starts ON directly.
    assign inc = evt_i && (state_q != StIdle) && !(terminal && !has_pending);
    assign dec = terminal && has_pending;

    sat_updown_counter #(
        .Max(MaxPending)
    ) u_pending (
        .clk   (clk_i),
        .rst   (rst_i),
        .inc   (inc),
        .dec   (dec),
        .count (pending_o),
        .drop  (overflow_o)
    );
`else
    logic ovf_q;

    assign has_pending = 1'b0;
    assign pending_o   = '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= evt_i && (state_q != StIdle) && !terminal;
        end
    end

    assign overflow_o = ovf_q;
`endif

endmodule
